// File: rtl/prng_share_ctrl_pkg.sv
// Shared types and defaults for the LFSR randomness-sharing controller.
package prng_share_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RESEED = 2'd1,
    WARMUP = 2'd2,
    SERVE  = 2'd3
  } state_e;

  localparam int unsigned DefaultReseedInterval = 1024;
  localparam int unsigned DefaultWarmupCycles   = 8;

endpackage

// File: rtl/prng_rr_arb.sv
// Combinational round-robin arbiter: the first active request at or after ptr_i wins.
module prng_rr_arb #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic              en_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] cand;
  int              sum;

  // Scan from the farthest candidate back to ptr_i so the nearest active request is written last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    sum   = 0;
    if (en_i) begin
      for (int k = int'(NumReq) - 1; k >= 0; k--) begin
        sum = int'(ptr_i) + k;
        if (sum >= int'(NumReq)) sum = sum - int'(NumReq);
        cand = IdxW'(sum);
        if (req_i[cand]) begin
          gnt_o       = '0;
          gnt_o[cand] = 1'b1;
          idx_o       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/prng_share_ctrl.sv
// Sequences a shared prim_lfsr: seeds it from the entropy source, warms it up, then
// hands one fresh LFSR step per cycle to a round-robin selected requester.
module prng_share_ctrl
  import prng_share_ctrl_pkg::*;
#(
  parameter int unsigned NumReq         = 3,
  parameter int unsigned LfsrDw         = 32,
  parameter int unsigned OutDw          = 8,
  parameter int unsigned ReseedInterval = DefaultReseedInterval,
  parameter int unsigned WarmupCycles   = DefaultWarmupCycles
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [OutDw-1:0]  rand_o,
  input  logic              reseed_force_i,
  output logic              entropy_req_o,
  input  logic              entropy_ack_i,
  input  logic [LfsrDw-1:0] entropy_i,
  output logic              lfsr_seed_en_o,
  output logic [LfsrDw-1:0] lfsr_seed_o,
  output logic              lfsr_en_o,
  input  logic [OutDw-1:0]  lfsr_state_i,
  output logic              ready_o,
  output logic              ack_err_o
);

  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW  = (ReseedInterval > 0) ? $clog2(ReseedInterval + 1) : 1;
  localparam int unsigned WarmW = (WarmupCycles > 0) ? $clog2(WarmupCycles + 1) : 1;
  localparam logic [CntW-1:0]  CntLimit = CntW'(ReseedInterval);
  localparam logic [WarmW-1:0] WarmLast = (WarmupCycles > 0) ? WarmW'(WarmupCycles - 1) : '0;
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumReq - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [WarmW-1:0] warm_q, warm_d;
  logic [IdxW-1:0]  ptr_q, ptr_d, win;
  logic             force_q, force_d, force_now;
  logic             ereq_q, ereq_d;
  logic             err_q, err_d;
  logic             arb_en;
  logic [NumReq-1:0] gnt;

  prng_rr_arb #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_arb (
    .req_i (req_i),
    .en_i  (arb_en),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win)
  );

  assign arb_en      = (state_q == SERVE);
  assign gnt_o       = gnt;
  assign rand_o      = lfsr_state_i;
  assign lfsr_seed_o = entropy_i;
  assign entropy_req_o = ereq_q;
  assign ack_err_o   = err_q;

  // The counter saturates rather than wrapping so a disabled interval never retriggers.
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign force_now = force_q | (reseed_force_i & ((state_q == SERVE) | (state_q == WARMUP)));
  assign force_d   = (state_d == RESEED) ? 1'b0 : force_now;
  assign ereq_d    = (state_d == RESEED);
  assign err_d     = err_q | (entropy_ack_i & ~ereq_q);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    warm_d         = '0;
    ptr_d          = ptr_q;
    lfsr_seed_en_o = 1'b0;
    lfsr_en_o      = 1'b0;
    ready_o        = 1'b0;
    unique case (state_q)
      INIT: state_d = RESEED;
      RESEED: begin
        if (entropy_ack_i) begin
          lfsr_seed_en_o = 1'b1;
          cnt_d          = '0;
          state_d        = (WarmupCycles == 0) ? SERVE : WARMUP;
        end
      end
      WARMUP: begin
        lfsr_en_o = 1'b1;
        warm_d    = warm_q + 1'b1;
        if (warm_q == WarmLast) begin
          warm_d  = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        ready_o = 1'b1;
        if (|gnt) begin
          lfsr_en_o = 1'b1;
          cnt_d     = cnt_inc;
          ptr_d     = (win == IdxLast) ? '0 : win + 1'b1;
        end
        // A grant in the leaving cycle still consumes its own LFSR step.
        if (force_now || ((ReseedInterval != 0) && (|gnt) && (cnt_inc == CntLimit))) begin
          state_d = RESEED;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
      warm_q  <= '0;
      ptr_q   <= '0;
      force_q <= 1'b0;
      ereq_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      ptr_q   <= ptr_d;
      force_q <= force_d;
      ereq_q  <= ereq_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_prng_share_ctrl.sv
// Bench for prng_share_ctrl paired with a small Galois LFSR standing in for prim_lfsr.
module tb_prng_share_ctrl;
  localparam int N  = 3;
  localparam int RI = 1024;
  localparam int WU = 8;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rst_ni, force_i, ack;
  logic [2:0]  req, gnt;
  logic [31:0] entropy, seed, peer_lfsr;
  logic [7:0]  rand_w, lfsr_state;
  logic        ereq, seed_en, lfsr_en, ready, ack_err;

  logic        r4_rst_ni, r4_force, r4_ack;
  logic [2:0]  r4_req, r4_gnt;
  logic [31:0] r4_entropy, r4_seed;
  logic [7:0]  r4_rand, r4_state;
  logic        r4_ereq, r4_seed_en, r4_lfsr_en, r4_ready, r4_ack_err;

  prng_share_ctrl #(.NumReq(N), .LfsrDw(32), .OutDw(8), .ReseedInterval(RI), .WarmupCycles(WU)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt), .rand_o(rand_w),
    .reseed_force_i(force_i), .entropy_req_o(ereq), .entropy_ack_i(ack), .entropy_i(entropy),
    .lfsr_seed_en_o(seed_en), .lfsr_seed_o(seed), .lfsr_en_o(lfsr_en), .lfsr_state_i(lfsr_state),
    .ready_o(ready), .ack_err_o(ack_err)
  );

  prng_share_ctrl #(.NumReq(N), .LfsrDw(32), .OutDw(8), .ReseedInterval(4), .WarmupCycles(WU)) u_dut_ri4 (
    .clk_i(clk), .rst_ni(r4_rst_ni), .req_i(r4_req), .gnt_o(r4_gnt), .rand_o(r4_rand),
    .reseed_force_i(r4_force), .entropy_req_o(r4_ereq), .entropy_ack_i(r4_ack), .entropy_i(r4_entropy),
    .lfsr_seed_en_o(r4_seed_en), .lfsr_seed_o(r4_seed), .lfsr_en_o(r4_lfsr_en), .lfsr_state_i(r4_state),
    .ready_o(r4_ready), .ack_err_o(r4_ack_err)
  );

  assign r4_state = 8'h00;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction

  // Stand-in for prim_lfsr, driven only by the DUT's control outputs.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)      peer_lfsr <= 32'h1;
    else if (seed_en) peer_lfsr <= seed;
    else if (lfsr_en) peer_lfsr <= lfsr_step(peer_lfsr);
  end
  assign lfsr_state = peer_lfsr[7:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef enum int {M_INIT, M_RESEED, M_WARM, M_SERVE} mphase_e;
  mphase_e     m_ph;
  int          m_left, m_grants, m_ptr;
  bit          m_force, m_err, m_leave;
  logic [31:0] m_lfsr;
  logic [2:0]  e_gnt;
  bit          e_ereq, e_seed_en, e_lfsr_en, e_ready;

  function automatic logic [2:0] rr_pick(input logic [2:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return 3'b001 << ((p + k) % N);
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_ph = M_INIT; m_left = 0; m_grants = 0; m_ptr = 0; m_force = 0; m_err = 0;
  endtask

  initial begin : compare
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_ni) model_reset();
      e_gnt     = (m_ph == M_SERVE) ? rr_pick(req, m_ptr) : 3'b000;
      e_ereq    = (m_ph == M_RESEED);
      e_seed_en = (m_ph == M_RESEED) && ack;
      e_lfsr_en = (m_ph == M_WARM) || (e_gnt != 3'b000);
      e_ready   = (m_ph == M_SERVE);
      check("m_gnt", gnt, e_gnt);
      check("m_ereq", ereq, e_ereq);
      check("m_seed_en", seed_en, e_seed_en);
      check("m_lfsr_en", lfsr_en, e_lfsr_en);
      check("m_ready", ready, e_ready);
      check("m_ack_err", ack_err, m_err);
      if (e_seed_en) check("m_seed", seed, entropy);
      if (e_gnt != 3'b000) check("m_rand", rand_w, m_lfsr[7:0]);
      @(posedge clk);
      if (!rst_ni) model_reset();
      else begin
        if (ack && !e_ereq) m_err = 1;
        case (m_ph)
          M_INIT: m_ph = M_RESEED;
          M_RESEED: if (ack) begin
            m_lfsr = entropy; m_grants = 0;
            if (WU == 0) m_ph = M_SERVE;
            else begin m_ph = M_WARM; m_left = WU; end
          end
          M_WARM: begin
            m_lfsr = lfsr_step(m_lfsr);
            if (force_i) m_force = 1;
            m_left--;
            if (m_left == 0) m_ph = M_SERVE;
          end
          default: begin
            m_leave = m_force || force_i;
            if (e_gnt != 3'b000) begin
              m_lfsr = lfsr_step(m_lfsr);
              if (m_grants < RI) m_grants++;
              for (int k = 0; k < N; k++) if (e_gnt[k]) m_ptr = (k + 1) % N;
              if (m_grants == RI) m_leave = 1;
            end
            if (m_leave) begin m_ph = M_RESEED; m_force = 0; end
          end
        endcase
      end
    end
  end

  logic [2:0] t2_exp [6];

  initial begin : stim
    t2_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rst_ni = 0; req = 0; force_i = 0; ack = 0; entropy = 0;
    r4_rst_ni = 0; r4_req = 0; r4_force = 0; r4_ack = 0; r4_entropy = 0;

    // Reset state, then seeding with DEADBEEF and warmup.
    step(3);
    check("rst_ereq", ereq, 0); check("rst_ready", ready, 0); check("rst_gnt", gnt, 0);
    check("rst_lfsr_en", lfsr_en, 0); check("rst_seed_en", seed_en, 0); check("rst_ack_err", ack_err, 0);
    rst_ni = 1;
    step(1); #1 check("t1_ereq_c2", ereq, 1);
    step(2); ack = 1; entropy = 32'hDEADBEEF; #1;
    check("t1_seed_en", seed_en, 1); check("t1_seed", seed, 32'hDEADBEEF); check("t1_no_step", lfsr_en, 0);
    step(1); ack = 0; entropy = 0; #1;
    check("t1_ereq_drop", ereq, 0); check("t1_seed_pulse", seed_en, 0);
    check("t1_warm_en", lfsr_en, 1); check("t1_rand_seed", rand_w, 8'hEF);
    step(1); #1 check("t1_rand_step", rand_w, 8'h74);
    step(6); #1 check("t1_warm_last", lfsr_en, 1); check("t1_not_ready", ready, 0);
    step(1); #1 check("t1_ready", ready, 1);

    // All three requesting: strict rotation.
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1 check("t2_gnt", gnt, t2_exp[i]); check("t2_step", lfsr_en, 1);
      step(1);
    end
    req = 3'b000;

    // Force in SERVE, then force during WARMUP with a request pending.
    #1 force_i = 1; #1 check("t4_pre_ready", ready, 1);
    step(1); force_i = 0; #1 check("t4_reseed", ereq, 1); check("t4_reseed_rdy", ready, 0);
    req = 3'b010;
    step(1); #1 check("t4_hold", gnt, 0);
    ack = 1; entropy = 32'h12345678;
    step(1); ack = 0;
    step(1); force_i = 1;
    step(1); force_i = 0;
    step(5); #1 check("t4_w8", lfsr_en, 1); check("t4_w8_gnt", gnt, 0);
    step(1); #1 check("t4_serve", ready, 1); check("t4_gnt", gnt, 3'b010);
    step(1); req = 0; #1 check("t4_back", ereq, 1); check("t4_back_rdy", ready, 0); check("t4_back_gnt", gnt, 0);
    ack = 1; entropy = 32'hCAFEF00D;
    step(1); ack = 0;
    step(8); #1 check("t4_resume", ready, 1);

    // Stray ack in SERVE.
    req = 3'b001; #1 check("t6_gnt0", gnt, 3'b001);
    ack = 1; entropy = 32'hFFFFFFFF; #1 check("t6_no_seed", seed_en, 0); check("t6_err_pre", ack_err, 0);
    step(1); ack = 0; #1 check("t6_err", ack_err, 1); check("t6_gnt1", gnt, 3'b001);
    step(3); #1 check("t6_err_sticky", ack_err, 1); check("t6_gnt2", gnt, 3'b001); check("t6_ready", ready, 1);
    req = 0;

    // Reset asserted mid-handshake.
    step(1); force_i = 1;
    step(1); force_i = 0; #1 check("t5_ereq", ereq, 1);
    #1 rst_ni = 0;
    #1 check("t5_ereq_drop", ereq, 0); check("t5_err_clr", ack_err, 0); check("t5_ready", ready, 0);
    step(2); rst_ni = 1; #1 check("t5_init", ereq, 0);
    step(1); #1 check("t5_restart", ereq, 1);
    ack = 1; entropy = 32'h00000001;
    step(1); ack = 0;
    step(8); #1 check("t5_ready_again", ready, 1);
    req = 3'b011; #1 check("t5_ptr_reset", gnt, 3'b001);
    step(1); req = 0;

    // ReseedInterval=4 instance with requester 0 held high from INIT.
    r4_req = 3'b001; r4_rst_ni = 1; #1 check("t3_init_gnt", r4_gnt, 0);
    step(1); #1 check("t3_ereq", r4_ereq, 1);
    r4_ack = 1; r4_entropy = 32'h0BADF00D; #1 check("t3_seed", r4_seed, 32'h0BADF00D); check("t3_seed_en", r4_seed_en, 1);
    step(1); r4_ack = 0; #1 check("t3_warm_gnt", r4_gnt, 0); check("t3_warm_en", r4_lfsr_en, 1);
    step(8);
    for (int i = 0; i < 4; i++) begin
      #1 check("t3_gnt", r4_gnt, 3'b001); check("t3_rand", r4_rand, 8'h00); check("t3_step", r4_lfsr_en, 1);
      step(1);
    end
    #1 check("t3_no_gnt", r4_gnt, 0); check("t3_reseed", r4_ereq, 1); check("t3_not_ready", r4_ready, 0);
    r4_ack = 1; r4_entropy = 32'h5555AAAA;
    step(1); r4_ack = 0; #1 check("t3_warm2_gnt", r4_gnt, 0);
    step(8); #1 check("t3_resume", r4_gnt, 3'b001); check("t3_ready", r4_ready, 1); check("t3_ack_err", r4_ack_err, 0);

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
